// File: rtl/fifo_burst_drain_pkg.sv
// rtl/fifo_burst_drain_pkg.sv - shared types and helpers for the FIFO burst drain
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_e;

  localparam int LEN_W   = 5;
  localparam int TIMER_W = 16;

  function automatic logic [31:0] beats_to_bytes(input logic [LEN_W-1:0] beats,
                                                 input int unsigned      bytes_per_beat);
    return 32'(beats) * 32'(bytes_per_beat);
  endfunction

endpackage

// File: rtl/fifo_burst_drain_if.sv
// rtl/fifo_burst_drain_if.sv - FIFO read side, burst command and write data bundle
interface fifo_burst_drain_if #(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 5,
  parameter int AW         = 32
);
  logic                  rd_ena;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  rd_empty;
  logic [CNT_WIDTH-1:0]  rd_dat_cnt;
  logic                  flush;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [AW-1:0]         cmd_addr;
  logic [4:0]            cmd_len;
  logic                  wd_valid;
  logic                  wd_ready;
  logic [DATA_WIDTH-1:0] wd_data;
  logic                  wd_last;
  logic                  busy;

  modport master (
    output rd_ena, cmd_valid, cmd_addr, cmd_len, wd_valid, wd_data, wd_last, busy,
    input  rd_dat, rd_empty, rd_dat_cnt, flush, cmd_ready, wd_ready
  );

  modport slave (
    input  rd_ena, cmd_valid, cmd_addr, cmd_len, wd_valid, wd_data, wd_last, busy,
    output rd_dat, rd_empty, rd_dat_cnt, flush, cmd_ready, wd_ready
  );
endinterface

// File: rtl/fifo_burst_drain_skid_buf2.sv
// rtl/fifo_burst_drain_skid_buf2.sv - 2-entry fall-through valid/ready buffer
// Upstream has no ready: the producer limits itself using the count output.
module skid_buf2 #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);

  logic [W-1:0] r_mem [2];
  logic         r_head;
  logic         r_tail;
  logic [1:0]   r_count;

  logic w_empty;
  logic w_push;
  logic w_pop_mem;

  assign w_empty   = (r_count == 2'd0);
  assign out_valid = !w_empty || in_valid;
  assign out_data  = w_empty ? in_data : r_mem[r_head];
  assign count     = r_count;

  // An arriving word bypasses storage when the buffer is empty and the sink takes it now.
  assign w_push    = in_valid && !(w_empty && out_ready);
  assign w_pop_mem = out_ready && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= in_data;
        r_tail        <= ~r_tail;
      end
      if (w_pop_mem) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop_mem};
    end
  end

endmodule

// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - drains the width-adapter FIFO into (addr, len) write bursts
module fifo_burst_drain
  import fifo_burst_pkg::*;
#(
  parameter int          DATA_WIDTH = 128,
  parameter int          CNT_WIDTH  = 5,
  parameter int unsigned BURST_LEN  = 4,
  parameter int          AW         = 32,
  parameter logic [AW-1:0] BASE_ADDR  = '0,
  parameter logic [AW:0]   ADDR_LIMIT = 'h10000,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic               clk,
  input logic               rst,
  fifo_burst_drain_if.master bus
);

  localparam int unsigned  BYTES     = DATA_WIDTH / 8;
  localparam logic [AW:0]  LIMIT_END = {1'b0, BASE_ADDR} + ADDR_LIMIT;

  state_e                   r_state;
  state_e                   w_next;
  logic [AW-1:0]            r_addr;
  logic [LEN_W-1:0]         r_len;
  logic [LEN_W-1:0]         r_reads;
  logic [LEN_W-1:0]         r_beats;
  logic [TIMER_W-1:0]       r_timer;
  logic                     r_flush_pend;
  logic                     r_inflight;

  logic [LEN_W-1:0]         w_avail_len;
  logic                     w_full;
  logic                     w_timed_out;
  logic                     w_start;
  logic                     w_credit;
  logic                     w_rd_ena;
  logic                     w_skid_valid;
  logic [DATA_WIDTH-1:0]    w_skid_data;
  logic [1:0]               w_skid_cnt;
  logic                     w_in_data;
  logic                     w_wd_valid;
  logic                     w_wd_last;
  logic                     w_beat_hs;
  logic                     w_last_hs;
  logic [AW:0]              w_addr_sum;
  logic [AW-1:0]            w_next_addr;

  assign w_full      = 32'(bus.rd_dat_cnt) >= BURST_LEN;
  assign w_timed_out = (TIMEOUT != 0) && (32'(r_timer) == TIMEOUT);
  assign w_start     = (r_state == ST_IDLE) &&
                       (w_full || (!bus.rd_empty && (r_flush_pend || w_timed_out)));

  always_comb begin
    w_avail_len = LEN_W'(BURST_LEN);
    if (!w_full) begin
      w_avail_len = (bus.rd_dat_cnt == '0) ? LEN_W'(1) : LEN_W'(bus.rd_dat_cnt);
    end
  end

  // Outstanding reads plus buffered words never exceed the two skid slots.
  assign w_in_data = (r_state == ST_DATA);
  assign w_credit  = ({1'b0, w_skid_cnt} + {2'b00, r_inflight}) < 3'd2;
  assign w_rd_ena  = w_in_data && !bus.rd_empty && (r_reads < r_len) && w_credit;

  assign w_wd_valid = w_in_data && w_skid_valid;
  assign w_wd_last  = w_wd_valid && (r_beats == r_len - LEN_W'(1));
  assign w_beat_hs  = w_wd_valid && bus.wd_ready;
  assign w_last_hs  = w_beat_hs && w_wd_last;

  assign w_addr_sum  = {1'b0, r_addr} + (AW+1)'(beats_to_bytes(r_len, BYTES));
  assign w_next_addr = (w_addr_sum >= LIMIT_END) ? BASE_ADDR : w_addr_sum[AW-1:0];

  skid_buf2 #(
    .W(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (r_inflight),
    .in_data   (bus.rd_dat),
    .out_valid (w_skid_valid),
    .out_data  (w_skid_data),
    .out_ready (bus.wd_ready && w_in_data),
    .count     (w_skid_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.cmd_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next = ST_CMD;
        end
      end
      ST_CMD: begin
        bus.cmd_valid = 1'b1;
        if (bus.cmd_ready) begin
          w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_last_hs) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= BASE_ADDR;
      r_len        <= LEN_W'(1);
      r_reads      <= '0;
      r_beats      <= '0;
      r_timer      <= '0;
      r_flush_pend <= 1'b0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_rd_ena;

      if (w_start) begin
        r_len   <= w_avail_len;
        r_reads <= '0;
        r_beats <= '0;
      end else begin
        if (w_rd_ena) begin
          r_reads <= r_reads + LEN_W'(1);
        end
        if (w_beat_hs) begin
          r_beats <= r_beats + LEN_W'(1);
        end
      end

      if (w_last_hs) begin
        r_addr <= w_next_addr;
      end

      if (w_start || (r_state == ST_IDLE && bus.rd_empty)) begin
        r_timer <= '0;
      end else if (r_state == ST_IDLE && 32'(r_timer) < TIMEOUT) begin
        r_timer <= r_timer + TIMER_W'(1);
      end

      // A new pulse wins over the empty-FIFO clear so back-to-back flushes extend the drain.
      if (bus.flush) begin
        r_flush_pend <= 1'b1;
      end else if (r_state == ST_IDLE && bus.rd_empty) begin
        r_flush_pend <= 1'b0;
      end
    end
  end

  assign bus.rd_ena   = w_rd_ena;
  assign bus.cmd_addr = r_addr;
  assign bus.cmd_len  = r_len;
  assign bus.wd_valid = w_wd_valid;
  assign bus.wd_data  = w_skid_data;
  assign bus.wd_last  = w_wd_last;
  assign bus.busy     = (r_state != ST_IDLE) || r_flush_pend;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb/tb_fifo_burst_drain.sv - scoreboard bench for fifo_burst_drain
`timescale 1ns/1ps
module tb_fifo_burst_drain;

  localparam int          DW    = 128;
  localparam int          CW    = 5;
  localparam int          BL    = 4;
  localparam int          AW    = 32;
  localparam int          TO    = 64;
  localparam logic [31:0] BASE  = 32'h1000;
  localparam longint      LIMIT = 'h80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_burst_drain_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .AW(AW)) bus ();

  fifo_burst_drain #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .BURST_LEN  (BL),
    .AW         (AW),
    .BASE_ADDR  (BASE),
    .ADDR_LIMIT (33'h80),
    .TIMEOUT    (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model feeding the read side
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pend_q[$];
  logic          rd_seen = 1'b0;
  logic [DW-1:0] m_rd_dat = '0;
  logic          m_empty = 1'b1;
  logic [CW-1:0] m_cnt = '0;

  assign bus.rd_dat     = m_rd_dat;
  assign bus.rd_empty   = m_empty;
  assign bus.rd_dat_cnt = m_cnt;

  always @(negedge clk) rd_seen = bus.rd_ena;

  always @(posedge clk) begin
    if (rst) fifo_q.delete();
    else if (rd_seen && fifo_q.size() > 0) m_rd_dat <= fifo_q.pop_front();
    while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    m_empty <= (fifo_q.size() == 0);
    m_cnt   <= CW'(fifo_q.size());
  end

  bit rand_mode = 0;
  initial begin
    bus.cmd_ready = 1'b1;
    bus.wd_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        bus.wd_ready  = ($urandom_range(0, 1) == 1);
        bus.cmd_ready = ($urandom_range(0, 3) == 0);
      end else begin
        bus.wd_ready  = 1'b1;
        bus.cmd_ready = 1'b1;
      end
    end
  end

  // Scoreboard / monitor
  logic [DW-1:0] exp_data[$];
  int            exp_len[$];
  longint        cmd_log[$];
  longint        exp_addr = BASE;
  bit            in_burst = 0;
  bit            len_free = 0;
  int            beat = 0;
  int            cur_len = 0;
  int            cyc = 0;
  int            last_hs = 0;
  bit            cmd_hold_v = 0;
  logic [37:0]   cmd_hold = '0;
  bit            wd_hold_v = 0;
  logic [DW-1:0] wd_hold_d = '0;
  logic [1:0]    wd_hold_c = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_data.delete();
      exp_len.delete();
      in_burst   = 0;
      beat       = 0;
      exp_addr   = BASE;
      cmd_hold_v = 0;
      wd_hold_v  = 0;
    end else begin
      if (bus.rd_ena) check_eq("rd_underflow", bus.rd_empty, 0);
      if (cmd_hold_v) check_eq("cmd_hold", {bus.cmd_valid, bus.cmd_addr, bus.cmd_len}, cmd_hold);
      if (wd_hold_v) begin
        check_eq("wd_hold_data", bus.wd_data, wd_hold_d);
        check_eq("wd_hold_ctl", {bus.wd_valid, bus.wd_last}, wd_hold_c);
      end
      if (bus.wd_valid) check_eq("wd_before_cmd", in_burst, 1);
      if (bus.wd_valid && bus.wd_ready) begin
        if (exp_data.size() == 0) check_eq("wd_extra_beat", bus.wd_valid, 0);
        else check_eq("wd_data", bus.wd_data, exp_data.pop_front());
        check_eq("wd_last", bus.wd_last, beat == cur_len - 1);
        if (!rand_mode && beat > 0) check_eq("wd_gap", cyc - last_hs, 1);
        last_hs = cyc;
        beat++;
        if (beat == cur_len) begin
          in_burst = 0;
          exp_addr = exp_addr + cur_len * (DW / 8);
          if (exp_addr >= BASE + LIMIT) exp_addr = BASE;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        cmd_log.push_back(longint'(bus.cmd_addr));
        check_eq("cmd_addr", bus.cmd_addr, exp_addr[31:0]);
        if (exp_len.size() > 0) check_eq("cmd_len", bus.cmd_len, exp_len.pop_front());
        else if (!len_free) check_eq("cmd_unexpected", bus.cmd_valid, 0);
        else check_eq("cmd_len_range", (bus.cmd_len >= 1 && bus.cmd_len <= BL), 1);
        cur_len  = int'(bus.cmd_len);
        beat     = 0;
        in_burst = 1;
      end
      cmd_hold_v = bus.cmd_valid && !bus.cmd_ready;
      cmd_hold   = {bus.cmd_valid, bus.cmd_addr, bus.cmd_len};
      wd_hold_v  = bus.wd_valid && !bus.wd_ready;
      wd_hold_d  = bus.wd_data;
      wd_hold_c  = {bus.wd_valid, bus.wd_last};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      pend_q.push_back(DW'(base + i));
      exp_data.push_back(DW'(base + i));
    end
  endtask

  task automatic trickle(input int n, input int base);
    int sent = 0;
    for (int g = 0; g < 20000 && sent < n; g++) begin
      tick();
      if (fifo_q.size() + pend_q.size() < 16) begin
        load(1, base + sent);
        sent++;
      end
    end
    check_eq("trickle_sent", sent, n);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      if (!bus.busy && !bus.cmd_valid && exp_data.size() == 0 && exp_len.size() == 0 &&
          fifo_q.size() == 0 && pend_q.size() == 0) done = 1;
    end
    check_eq(tag, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    int n;
    bus.flush = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check_eq("rst_rd_ena", bus.rd_ena, 0);
    check_eq("rst_cmd_valid", bus.cmd_valid, 0);
    check_eq("rst_wd_valid", bus.wd_valid, 0);
    check_eq("rst_wd_last", bus.wd_last, 0);
    check_eq("rst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;

    // two full bursts from 8 stored words
    tick();
    cmd_log.delete();
    exp_len.push_back(4);
    exp_len.push_back(4);
    load(8, 0);
    wait_drain("t1_drain", 200);
    check_eq("t1_ncmd", cmd_log.size(), 2);
    if (cmd_log.size() == 2) begin
      check_eq("t1_addr0", cmd_log[0], BASE);
      check_eq("t1_addr1", cmd_log[1], BASE + 'h40);
    end

    // idle timeout partial burst
    cmd_log.delete();
    exp_len.push_back(3);
    load(3, 100);
    found = 0;
    n = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (bus.cmd_valid) found = 1;
      else if (!bus.rd_empty) n++;
    end
    check_eq("t2_cmd_seen", found, 1);
    check_eq("t2_timeout_lat", n, TO + 1);
    wait_drain("t2_drain", 200);

    // flush with 6 words: 4 then 2
    cmd_log.delete();
    exp_len.push_back(4);
    exp_len.push_back(2);
    load(6, 200);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_drain("t3_drain", 200);
    check_eq("t3_ncmd", cmd_log.size(), 2);
    check_eq("t3_busy", bus.busy, 0);

    // flush with empty FIFO
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    check_eq("t3b_busy_set", bus.busy, 1);
    @(negedge clk);
    check_eq("t3b_busy_clr", bus.busy, 0);
    repeat (4) tick();
    check_eq("t3b_ncmd", cmd_log.size(), 2);

    // random back-pressure over 256 words
    rand_mode = 1;
    len_free  = 1;
    trickle(256, 1000);
    wait_drain("t4_drain", 4000);
    rand_mode = 0;
    len_free  = 0;
    tick();

    // reset in the middle of beat 2
    exp_len.push_back(4);
    load(4, 5000);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (in_burst && beat == 2) found = 1;
    end
    check_eq("t5_reach_beat2", found, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_cmd_valid", bus.cmd_valid, 0);
    check_eq("t5_wd_valid", bus.wd_valid, 0);
    check_eq("t5_rd_ena", bus.rd_ena, 0);
    check_eq("t5_busy", bus.busy, 0);
    tick();
    cmd_log.delete();
    exp_len.push_back(4);
    load(4, 6000);
    wait_drain("t5_drain", 200);
    check_eq("t5_ncmd", cmd_log.size(), 1);
    if (cmd_log.size() == 1) check_eq("t5_addr", cmd_log[0], BASE);

    // address wrap over 16 full bursts
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    cmd_log.delete();
    for (int i = 0; i < 16; i++) exp_len.push_back(4);
    trickle(64, 7000);
    wait_drain("t6_drain", 500);
    check_eq("t6_ncmd", cmd_log.size(), 16);
    for (int i = 0; i < 16 && i < cmd_log.size(); i++) begin
      check_eq($sformatf("t6_addr%0d", i), cmd_log[i], BASE + (i % 2) * 'h40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
